// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | morse_pkg                                                                  |
// | Shared types and character table for morse_tx. MORSE_TX_DIGITS_EN enables  |
// | digit codes 26-35.                                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MARK     = 3'd1,
        ST_SYM_GAP  = 3'd2,
        ST_CHAR_GAP = 3'd3,
        ST_WORD_GAP = 3'd4
    } morse_state_e;

    localparam logic [5:0] CODE_LETTER_A = 6'd0;
    localparam logic [5:0] CODE_DIGIT_0  = 6'd26;
    localparam logic [5:0] CODE_SPACE    = 6'd36;

    // Pattern bit i is symbol i (1 = dash); len == 0 marks a code with no symbols.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_entry_t;

    function automatic morse_entry_t morse_lookup(input logic [5:0] code);
        morse_entry_t e;
        case (code)
            6'd0:  e = {3'd2, 5'b00010};
            6'd1:  e = {3'd4, 5'b00001};
            6'd2:  e = {3'd4, 5'b00101};
            6'd3:  e = {3'd3, 5'b00001};
            6'd4:  e = {3'd1, 5'b00000};
            6'd5:  e = {3'd4, 5'b00100};
            6'd6:  e = {3'd3, 5'b00011};
            6'd7:  e = {3'd4, 5'b00000};
            6'd8:  e = {3'd2, 5'b00000};
            6'd9:  e = {3'd4, 5'b01110};
            6'd10: e = {3'd3, 5'b00101};
            6'd11: e = {3'd4, 5'b00010};
            6'd12: e = {3'd2, 5'b00011};
            6'd13: e = {3'd2, 5'b00001};
            6'd14: e = {3'd3, 5'b00111};
            6'd15: e = {3'd4, 5'b00110};
            6'd16: e = {3'd4, 5'b01011};
            6'd17: e = {3'd3, 5'b00010};
            6'd18: e = {3'd3, 5'b00000};
            6'd19: e = {3'd1, 5'b00001};
            6'd20: e = {3'd3, 5'b00100};
            6'd21: e = {3'd4, 5'b01000};
            6'd22: e = {3'd3, 5'b00110};
            6'd23: e = {3'd4, 5'b01001};
            6'd24: e = {3'd4, 5'b01101};
            6'd25: e = {3'd4, 5'b00011};
`ifdef MORSE_TX_DIGITS_EN
            6'd26: e = {3'd5, 5'b11111};
            6'd27: e = {3'd5, 5'b11110};
            6'd28: e = {3'd5, 5'b11100};
            6'd29: e = {3'd5, 5'b11000};
            6'd30: e = {3'd5, 5'b10000};
            6'd31: e = {3'd5, 5'b00000};
            6'd32: e = {3'd5, 5'b00001};
            6'd33: e = {3'd5, 5'b00011};
            6'd34: e = {3'd5, 5'b00111};
            6'd35: e = {3'd5, 5'b01111};
`endif
            default: e = {3'd0, 5'b00000};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | morse_unit_timer                                                           |
// | Loadable down-counter that holds at zero; load has priority.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module morse_unit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/morse_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | morse_tx                                                                   |
// | Character-at-a-time Morse keyer; MORSE_TX_DIGITS_EN adds digits 0-9.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 100,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_char,
    output logic       out,
    output logic       busy,
    output logic       char_done,
    output logic       err
);

    localparam int c_max_units =
        (DASH_UNITS >= CHAR_GAP_UNITS)
            ? ((DASH_UNITS >= WORD_GAP_UNITS) ? DASH_UNITS : WORD_GAP_UNITS)
            : ((CHAR_GAP_UNITS >= WORD_GAP_UNITS) ? CHAR_GAP_UNITS : WORD_GAP_UNITS);
    localparam int c_cnt_w = $clog2(c_max_units * UNIT_CYCLES);

    localparam logic [c_cnt_w-1:0] c_dot_load  = c_cnt_w'(UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_dash_load = c_cnt_w'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_char_load = c_cnt_w'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_word_load = c_cnt_w'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    morse_state_e state_q, state_d;
    logic [5:0]   char_q, char_d;
    logic [2:0]   idx_q, idx_d;
    logic         err_q, err_d;

    logic               w_load;
    logic [c_cnt_w-1:0] w_load_val;
    logic [c_cnt_w-1:0] w_cnt;
    logic               w_tmr_zero;

    morse_entry_t w_entry;
    morse_entry_t w_in_entry;
    logic [4:0]   w_sel_pat;
    logic [7:0]   w_sel_pat8;
    logic [2:0]   w_sel_idx;
    logic         w_sym_dash;
    logic         w_last_sym;

    assign w_entry    = morse_lookup(char_q);
    assign w_in_entry = morse_lookup(in_char);

    // In IDLE the first symbol comes straight from the incoming code; later
    // symbols come from the latched code at the already-advanced index.
    assign w_sel_pat  = (state_q == ST_IDLE) ? w_in_entry.pattern : w_entry.pattern;
    assign w_sel_idx  = (state_q == ST_IDLE) ? 3'd0 : idx_q;
    assign w_sel_pat8 = {3'b000, w_sel_pat};
    assign w_sym_dash = w_sel_pat8[w_sel_idx];
    assign w_last_sym = ((idx_q + 3'd1) >= w_entry.len);

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        idx_d      = idx_q;
        err_d      = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_char == CODE_SPACE) begin
                        state_d    = ST_WORD_GAP;
                        w_load     = 1'b1;
                        w_load_val = c_word_load;
                    end else if (w_in_entry.len != 3'd0) begin
                        state_d    = ST_MARK;
                        char_d     = in_char;
                        idx_d      = 3'd0;
                        w_load     = 1'b1;
                        w_load_val = w_sym_dash ? c_dash_load : c_dot_load;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (w_tmr_zero) begin
                    w_load = 1'b1;
                    if (w_last_sym) begin
                        state_d    = ST_CHAR_GAP;
                        w_load_val = c_char_load;
                    end else begin
                        state_d    = ST_SYM_GAP;
                        idx_d      = idx_q + 3'd1;
                        w_load_val = c_dot_load;
                    end
                end
            end
            ST_SYM_GAP: begin
                if (w_tmr_zero) begin
                    state_d    = ST_MARK;
                    w_load     = 1'b1;
                    w_load_val = w_sym_dash ? c_dash_load : c_dot_load;
                end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
                if (w_tmr_zero) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            char_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    morse_unit_timer #(
        .CNT_W(c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .value_o    (w_cnt),
        .zero_o     (w_tmr_zero)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out       = (state_q == ST_MARK);
    assign char_done = ((state_q == ST_CHAR_GAP) || (state_q == ST_WORD_GAP)) && (w_cnt == '0);
    assign err       = err_q;

endmodule
`default_nettype wire
